bcd_stream_converter: RTL and testbench

//  Sequential double-dabble binary-to-BCD converter. Its width, digit count and bits-per-cycle are set by parameters.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_shift_step.sv | 25 ++
 rtl/bcd_stream_converter.sv | 140 ++++++++++++++
 tb/tb_bcd_stream_converter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential double-dabble BCD converter.
// Optional signed-operand support is controlled by the BCD_SIGNED_EN macro in the top module.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Double-dabble correction: a digit of 5 or more would reach 10+ after the shift.
  function automatic logic [3:0] add3_adjust(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bcd_shift_step.sv
// One double-dabble micro-step: per-digit +3 adjust, then a 1-bit shift-in of the next operand bit.
// Purely combinational; the top chains BPC of these per clock (BCD_SIGNED_EN has no effect here).
module bcd_shift_step
  import bcd_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [BCD_DIGIT_W*DIGITS-1:0] acc_in,
  input  logic                          bin_msb,
  output logic [BCD_DIGIT_W*DIGITS-1:0] acc_out,
  output logic                          ovf_out
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;

  logic [ACC_W-1:0] adjusted;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    assign adjusted[d*BCD_DIGIT_W +: BCD_DIGIT_W] = add3_adjust(acc_in[d*BCD_DIGIT_W +: BCD_DIGIT_W]);
  end

  assign acc_out = {adjusted[ACC_W-2:0], bin_msb};
  assign ovf_out = adjusted[ACC_W-1];

endmodule

// File: rtl/bcd_stream_converter.sv
// Handshaked sequential binary-to-BCD converter with sticky overflow detection.
// Define BCD_SIGNED_EN to treat binary_i as two's complement and expose sign_o.
module bcd_stream_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int BPC    = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          start_i,
  input  logic [BIN_W-1:0]              binary_i,
  output logic                          ready_o,
  output logic                          valid_o,
  input  logic                          ack_i,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
  output logic                          overflow_o
`ifdef BCD_SIGNED_EN
  ,
  output logic                          sign_o
`endif
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int STEPS = BIN_W / BPC;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] bcd_q, bcd_d;
  logic             ovfOut_q, ovfOut_d;

  logic [BIN_W-1:0] operand;
  logic [ACC_W-1:0] accChain [BPC+1];
  logic [BPC-1:0]   ovfChain;
  logic             stepOvf;

`ifdef BCD_SIGNED_EN
  // Negating in BIN_W bits maps the most negative value onto its own unsigned magnitude.
  assign operand = binary_i[BIN_W-1] ? (BIN_W'(0) - binary_i) : binary_i;
`else
  assign operand = binary_i;
`endif

  assign accChain[0] = acc_q;
  for (genvar g = 0; g < BPC; g++) begin : g_step
    bcd_shift_step #(.DIGITS(DIGITS)) u_step (
      .acc_in (accChain[g]),
      .bin_msb(bin_q[BIN_W-1-g]),
      .acc_out(accChain[g+1]),
      .ovf_out(ovfChain[g])
    );
  end
  assign stepOvf = |ovfChain;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    bcd_d    = bcd_q;
    ovfOut_d = ovfOut_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SHIFT;
          bin_d   = operand;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_LOAD;
        end
      end
      SHIFT: begin
        acc_d = accChain[BPC];
        bin_d = bin_q << BPC;
        ovf_d = ovf_q | stepOvf;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = HOLD;
          bcd_d    = accChain[BPC];
          ovfOut_d = ovf_q | stepOvf;
        end
      end
      HOLD: begin
        if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bin_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      bcd_q    <= '0;
      ovfOut_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      bcd_q    <= bcd_d;
      ovfOut_q <= ovfOut_d;
    end
  end

`ifdef BCD_SIGNED_EN
  logic signCap_q;
  logic sign_q;

  // Sign is captured on acceptance but only published on HOLD entry, alongside the digits.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      signCap_q <= 1'b0;
      sign_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && start_i) signCap_q <= binary_i[BIN_W-1];
      if (state_q == SHIFT && cnt_q == '0) sign_q <= signCap_q;
    end
  end

  assign sign_o = sign_q;
`endif

  assign ready_o    = (state_q == IDLE);
  assign valid_o    = (state_q == HOLD);
  assign bcd_o      = bcd_q;
  assign overflow_o = ovfOut_q;

endmodule

// File: tb/tb_bcd_stream_converter.sv
// Directed self-checking bench for bcd_stream_converter: default, DIGITS=4 and BPC=4 instances.
// Signed scenarios are compiled in only when BCD_SIGNED_EN is defined.
module tb_bcd_stream_converter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  start = 3'b000;
  logic [15:0] binaryIn = 16'd0;
  logic        ack = 1'b0;

  wire [2:0]  ready, valid, ovf;
  wire [19:0] bcdA, bcdC;
  wire [15:0] bcdB;
`ifdef BCD_SIGNED_EN
  wire [2:0]  sign;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_stream_converter dutA (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start[0]), .binary_i(binaryIn),
    .ready_o(ready[0]), .valid_o(valid[0]), .ack_i(ack), .bcd_o(bcdA), .overflow_o(ovf[0])
`ifdef BCD_SIGNED_EN
    , .sign_o(sign[0])
`endif
  );

  bcd_stream_converter #(.DIGITS(4)) dutB (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start[1]), .binary_i(binaryIn),
    .ready_o(ready[1]), .valid_o(valid[1]), .ack_i(ack), .bcd_o(bcdB), .overflow_o(ovf[1])
`ifdef BCD_SIGNED_EN
    , .sign_o(sign[1])
`endif
  );

  bcd_stream_converter #(.BPC(4)) dutC (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start[2]), .binary_i(binaryIn),
    .ready_o(ready[2]), .valid_o(valid[2]), .ack_i(ack), .bcd_o(bcdC), .overflow_o(ovf[2])
`ifdef BCD_SIGNED_EN
    , .sign_o(sign[2])
`endif
  );

  // Accept one operand on instance sel and count edges (acceptance edge = 1) until valid_o.
  task automatic convert(input int sel, input logic [15:0] v, output int cycles, output bit readyBad);
    @(negedge clk);
    binaryIn   = v;
    start[sel] = 1'b1;
    @(posedge clk);
    cycles = 1;
    #1 start[sel] = 1'b0;
    readyBad = 1'b0;
    while (valid[sel] !== 1'b1 && cycles < 100) begin
      if (ready[sel] !== 1'b0) readyBad = 1'b1;
      @(posedge clk);
      cycles++;
      #1;
    end
    if (ready[sel] !== 1'b0) readyBad = 1'b1;
  endtask

  task automatic transfer();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (ready !== 3'b111 || valid !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_handshake: ready=%b valid=%b, required ready=111 valid=000", ready, valid);
    end
    checks++;
    if (bcdA !== 20'h0 || bcdB !== 16'h0 || bcdC !== 20'h0 || ovf !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: bcdA=%h bcdB=%h bcdC=%h ovf=%b, required all zero", bcdA, bcdB, bcdC, ovf);
    end
`ifdef BCD_SIGNED_EN
    checks++;
    if (sign !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_sign: sign=%b, required 000", sign);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_max_value();
    int  cycles;
    bit  readyBad;
    ack = 1'b1;
    convert(0, 16'hFFFF, cycles, readyBad);
    checks++;
    if (cycles !== 17) begin
      failures++;
      $display("[TB] FAIL max_latency: got %0d cycles, required 17", cycles);
    end
    checks++;
    if (bcdA !== 20'h65535 || ovf[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL max_value: bcd=%h ovf=%b, required 65535 ovf=0", bcdA, ovf[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid[0] !== 1'b0 || ready[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL max_release: valid=%b ready=%b, required valid=0 ready=1", valid[0], ready[0]);
    end
    ack = 1'b0;
  endtask

  task automatic test_small_values();
    int cycles;
    bit readyBad;
    convert(0, 16'd0, cycles, readyBad);
    checks++;
    if (bcdA !== 20'h00000 || readyBad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_value: bcd=%h readyBad=%b, required 00000 readyBad=0", bcdA, readyBad);
    end
    transfer();
    convert(0, 16'd9, cycles, readyBad);
    checks++;
    if (bcdA !== 20'h00009 || readyBad !== 1'b0 || cycles !== 17) begin
      failures++;
      $display("[TB] FAIL nine_value: bcd=%h readyBad=%b cycles=%0d, required 00009 0 17", bcdA, readyBad, cycles);
    end
    transfer();
    checks++;
    if (bcdA !== 20'h00009 || valid[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nine_retained: bcd=%h valid=%b, required 00009 valid=0", bcdA, valid[0]);
    end
  endtask

  task automatic test_overflow();
    int cycles;
    bit readyBad;
    convert(1, 16'd12345, cycles, readyBad);
    checks++;
    if (ovf[1] !== 1'b1 || bcdB !== 16'h2345) begin
      failures++;
      $display("[TB] FAIL overflow_set: bcd=%h ovf=%b, required 2345 ovf=1", bcdB, ovf[1]);
    end
    transfer();
    checks++;
    if (ovf[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overflow_retained: ovf=%b, required 1", ovf[1]);
    end
    convert(1, 16'd42, cycles, readyBad);
    checks++;
    if (ovf[1] !== 1'b0 || bcdB !== 16'h0042) begin
      failures++;
      $display("[TB] FAIL overflow_cleared: bcd=%h ovf=%b, required 0042 ovf=0", bcdB, ovf[1]);
    end
    transfer();
  endtask

  task automatic test_hold_stall();
    int cycles;
    bit readyBad;
    bit stableBad = 1'b0;
    convert(2, 16'd40960, cycles, readyBad);
    checks++;
    if (cycles !== 5 || bcdC !== 20'h40960) begin
      failures++;
      $display("[TB] FAIL bpc4_value: bcd=%h cycles=%0d, required 40960 5", bcdC, cycles);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start[2] = ~i[0];
      binaryIn = 16'(i * 1111);
      @(posedge clk);
      #1;
      if (bcdC !== 20'h40960 || valid[2] !== 1'b1 || ovf[2] !== 1'b0 || ready[2] !== 1'b0) stableBad = 1'b1;
    end
    start[2] = 1'b0;
    checks++;
    if (stableBad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_stable: unstable=%b, required 0", stableBad);
    end
    transfer();
    checks++;
    if (ready[2] !== 1'b1 || valid[2] !== 1'b0 || bcdC !== 20'h40960) begin
      failures++;
      $display("[TB] FAIL hold_release: ready=%b valid=%b bcd=%h, required 1 0 40960", ready[2], valid[2], bcdC);
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    bit readyBad;
    @(negedge clk);
    binaryIn = 16'd5000;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ready[0] !== 1'b1 || valid[0] !== 1'b0 || bcdA !== 20'h0 || ovf[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset: ready=%b valid=%b bcd=%h ovf=%b, required 1 0 00000 0", ready[0], valid[0], bcdA, ovf[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    convert(0, 16'd100, cycles, readyBad);
    checks++;
    if (bcdA !== 20'h00100 || cycles !== 17) begin
      failures++;
      $display("[TB] FAIL after_reset: bcd=%h cycles=%0d, required 00100 17", bcdA, cycles);
    end
    transfer();
  endtask

  task automatic test_back_to_back();
    int  rises[$];
    logic prev;
    @(negedge clk);
    ack      = 1'b1;
    binaryIn = 16'd777;
    start[0] = 1'b1;
    prev     = valid[0];
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (valid[0] === 1'b1 && prev !== 1'b1) rises.push_back(c);
      prev = valid[0];
    end
    start[0] = 1'b0;
    checks++;
    if (rises.size() < 2 || (rises[1] - rises[0]) != 18) begin
      failures++;
      $display("[TB] FAIL throughput: rises=%0d period=%0d, required period 18",
               rises.size(), (rises.size() >= 2) ? rises[1] - rises[0] : -1);
    end
    checks++;
    if (bcdA !== 20'h00777) begin
      failures++;
      $display("[TB] FAIL throughput_value: bcd=%h, required 00777", bcdA);
    end
    repeat (25) @(posedge clk);
    #1 ack = 1'b0;
  endtask

`ifdef BCD_SIGNED_EN
  task automatic test_signed();
    int cycles;
    bit readyBad;
    convert(0, 16'hFB2E, cycles, readyBad);
    checks++;
    if (sign[0] !== 1'b1 || bcdA !== 20'h01234) begin
      failures++;
      $display("[TB] FAIL signed_1234: sign=%b bcd=%h, required 1 01234", sign[0], bcdA);
    end
    transfer();
    convert(0, 16'h8000, cycles, readyBad);
    checks++;
    if (sign[0] !== 1'b1 || bcdA !== 20'h32768 || ovf[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL signed_min: sign=%b bcd=%h ovf=%b, required 1 32768 0", sign[0], bcdA, ovf[0]);
    end
    transfer();
    convert(0, 16'd321, cycles, readyBad);
    checks++;
    if (sign[0] !== 1'b0 || bcdA !== 20'h00321) begin
      failures++;
      $display("[TB] FAIL signed_positive: sign=%b bcd=%h, required 0 00321", sign[0], bcdA);
    end
    transfer();
  endtask
`endif

  initial begin
    test_reset();
    test_max_value();
    test_small_values();
    test_overflow();
    test_hold_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef BCD_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
